mac_feeder: RTL and testbench
=============================

Name: mac_feeder

Overview:
- Producer/consumer for the 16-lane 8x8 MAC pipeline (mac2): packs an incoming pixel byte stream into 128-bit vectors and fetches the matching 128-bit weight row from a synchronous weight memory.
- Issues each vector pair to the MAC, collects the 20-bit MAC sum after the fixed pipeline latency, and accumulates NUM_CHUNKS sums into one neuron result returned on a valid/ready port.
- Sits between the image input stream / weight ROM and the neuron activation stage.

Parameters:
NUM_CHUNKS, 49, 16-pixel chunks per neuron (49*16 = 784 pixels)
ADDR_W, 6, weight memory address width; must satisfy 2^ADDR_W >= NUM_CHUNKS
MAC_LATENCY, 3, cycles from a mac_issue-high cycle to the cycle in which mac_sum holds that pair's sum
ACC_W, 26, accumulator/result width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pix_valid  in  1  pixel byte valid
pix_data  in  8  pixel byte, unsigned
pix_ready  out  1  feeder accepts byte this cycle
weight_rd_en  out  1  weight memory read strobe
weight_addr  out  ADDR_W  weight row index (= chunk index)
weight_rdata  in  128  weight row; valid the cycle after weight_rd_en
mac_pixels  out  128  packed pixels to MAC pixelsIn
mac_weights  out  128  weight row to MAC weightsIn
mac_issue  out  1  mac_pixels/mac_weights hold a new pair this cycle
mac_sum  in  20  MAC sumOut
res_valid  out  1  accumulated result valid
res_data  out  ACC_W  accumulated result, unsigned
res_ready  in  1  downstream accepts result

Behaviour:
- Reset (async, rst_n=0): state FILL, byte_cnt=0, chunk_idx=0, acc=0, in-flight shift register cleared. Outputs: pix_ready=0 while rst_n=0, then 1 in first FILL cycle; weight_rd_en=0, weight_addr=0, mac_pixels=0, mac_weights=0, mac_issue=0, res_valid=0, res_data=0. Reset mid-frame discards all partial data; no result is produced for the interrupted frame.
- Packing is MSB-first: byte k of a chunk (k=0..15) lands in mac_pixels[127-8k -: 8]. Weight byte lanes use the same order.
- States:
  - FILL: pix_ready=1; a byte is accepted when pix_valid & pix_ready. On the 16th byte (byte_cnt=15), go to FETCH and reset byte_cnt to 0.
  - FETCH, 1 cycle: pix_ready=0, weight_rd_en=1, weight_addr=chunk_idx. Go to LOAD.
  - LOAD, 1 cycle: pix_ready=0; at this cycle's closing edge, register the pack buffer -> mac_pixels and weight_rdata -> mac_weights, and set mac_issue for exactly the next cycle. Push an in-flight token tagged last=(chunk_idx==NUM_CHUNKS-1). Then:
    - if last: go to DRAIN;
    - else: increment chunk_idx and return to FILL.
  - DRAIN: pix_ready=0; wait until the last token has been accumulated, then go to RESULT with res_valid=1 and res_data=acc (final value).
  - RESULT: res_valid and res_data held stable until res_valid & res_ready. On that handshake edge: res_valid=0, acc=0, chunk_idx=0, go to FILL.
- mac_pixels and mac_weights hold their values between issues. mac_issue is a 1-cycle pulse.
- Accumulation: a token enters a MAC_LATENCY-deep shift register in the mac_issue cycle. In the cycle it exits, acc <= acc + zero-extended mac_sum. Addition is modulo 2^ACC_W, with no saturation.
- Minimum chunk period is 18 cycles (16 FILL + FETCH + LOAD), which exceeds MAC_LATENCY, so at most one token is in flight. The logic must still be correct for any MAC_LATENCY >= 1.
- pix_valid gaps stall FILL only; partial byte_cnt is held. Bytes offered while pix_ready=0 are not consumed.
- No frame overlap: the next frame's first byte is accepted only after the result handshake.

Test Plan:
1. NUM_CHUNKS=1; bytes 0x01..0x10 back-to-back; row 0 = all 0x02; real mac2 instance -> mac_pixels=0x0102030405060708090A0B0C0D0E0F10, mac_issue one cycle, res_data=272 at MAC_LATENCY+1 cycles after issue.
2. NUM_CHUNKS=49; all pixels and weights 0xFF -> each mac_sum=1040400; res_data=50979600; weight_addr steps 0..48, one weight_rd_en per chunk.
3. Random pix_valid gaps (~50%) on the same data as test 1 -> identical res_data and mac_pixels; pix_ready=0 in FETCH, LOAD, DRAIN and RESULT.
4. Hold res_ready=0 for 10 cycles after res_valid -> res_valid/res_data stable, pix_ready=0; the byte offered during the stall is accepted only after the handshake; second frame's weight_addr restarts at 0.
5. Assert rst_n=0 after 7 bytes of chunk 2, then run a full frame -> all outputs reset immediately; the new frame's result equals a clean single-frame result (no residue in acc).
6. NUM_CHUNKS=2; chunk0 pixels 0x01 and weights 0x03 (sum 48), chunk1 pixels 0x02 and weights 0x05 (sum 160) -> res_data=208, exactly one res_valid per frame.

Source files
------------

// File: rtl/mac_feeder.sv
// mac_feeder: packs a pixel byte stream into 128-bit chunks, fetches the matching weight row,
// issues each pair to the MAC pipeline and accumulates NUM_CHUNKS sums into one neuron result.
module mac_feeder #(
   parameter int NUM_CHUNKS  = 49,
   parameter int ADDR_W      = 6,
   parameter int MAC_LATENCY = 3,
   parameter int ACC_W       = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              pix_ready,
   output logic              weight_rd_en,
   output logic [ADDR_W-1:0] weight_addr,
   input  logic [127:0]      weight_rdata,
   output logic [127:0]      mac_pixels,
   output logic [127:0]      mac_weights,
   output logic              mac_issue,
   input  logic [19:0]       mac_sum,
   output logic              res_valid,
   output logic [ACC_W-1:0]  res_data,
   input  logic              res_ready
);
   typedef enum logic [2:0] {FILL, FETCH, LOAD, DRAIN, RESULT} state_t;

   state_t                 state;
   logic [3:0]             byteCnt;
   logic [ADDR_W-1:0]      chunkIdx;
   logic [ACC_W-1:0]       acc;
   logic [ACC_W-1:0]       accNext;
   logic [127:0]           packBuf;
   logic                   issueLast;
   logic [MAC_LATENCY-1:0] tokVld;
   logic [MAC_LATENCY-1:0] tokLast;
   logic                   tokExit;
   logic                   lastExit;
   logic                   isLast;

   assign isLast    = (chunkIdx == ADDR_W'(NUM_CHUNKS - 1));
   assign tokExit   = tokVld[MAC_LATENCY-1];
   assign lastExit  = tokExit & tokLast[MAC_LATENCY-1];
   assign accNext   = tokExit ? acc + ACC_W'(mac_sum) : acc;
   assign pix_ready = rst_n & (state == FILL);

   // Token shift written as a shift-or so a latency of 1 needs no special case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tokVld  <= '0;
         tokLast <= '0;
      end else begin
         tokVld  <= (tokVld << 1) | MAC_LATENCY'(mac_issue);
         tokLast <= (tokLast << 1) | MAC_LATENCY'(mac_issue & issueLast);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FILL;
         byteCnt      <= '0;
         chunkIdx     <= '0;
         acc          <= '0;
         packBuf      <= '0;
         issueLast    <= 1'b0;
         weight_rd_en <= 1'b0;
         weight_addr  <= '0;
         mac_pixels   <= '0;
         mac_weights  <= '0;
         mac_issue    <= 1'b0;
         res_valid    <= 1'b0;
         res_data     <= '0;
      end else begin
         acc          <= accNext;
         weight_rd_en <= 1'b0;
         mac_issue    <= 1'b0;
         case (state)
            FILL: begin
               // Shifting in from the LSB leaves byte 0 in the top lane after 16 bytes.
               if (pix_valid) begin
                  packBuf <= {packBuf[119:0], pix_data};
                  byteCnt <= byteCnt + 4'd1;
                  if (byteCnt == 4'd15) begin
                     state        <= FETCH;
                     weight_rd_en <= 1'b1;
                     weight_addr  <= chunkIdx;
                  end
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               mac_pixels  <= packBuf;
               mac_weights <= weight_rdata;
               mac_issue   <= 1'b1;
               issueLast   <= isLast;
               if (isLast) begin
                  state <= DRAIN;
               end else begin
                  chunkIdx <= chunkIdx + 1'b1;
                  state    <= FILL;
               end
            end
            DRAIN: begin
               if (lastExit) begin
                  state     <= RESULT;
                  res_valid <= 1'b1;
                  res_data  <= accNext;
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  acc       <= '0;
                  chunkIdx  <= '0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: drives random and patterned pixel frames through mac_feeder with a behavioural
// weight memory and MAC model, and checks results against a frame-level dot-product reference.
module tb_mac_feeder;
   localparam int NC   = 49;
   localparam int AW   = 6;
   localparam int LAT  = 3;
   localparam int AccW = 26;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pix_valid = 1'b0;
   logic [7:0]      pix_data = '0;
   logic            pix_ready;
   logic            weight_rd_en;
   logic [AW-1:0]   weight_addr;
   logic [127:0]    weight_rdata = '0;
   logic [127:0]    mac_pixels;
   logic [127:0]    mac_weights;
   logic            mac_issue;
   logic [19:0]     mac_sum;
   logic            res_valid;
   logic [AccW-1:0] res_data;
   logic            res_ready = 1'b0;

   int compared = 0;
   int mismatched = 0;

   logic [7:0]   pixB [NC*16];
   logic [7:0]   wB [NC][16];
   logic [127:0] wRow [64];
   logic [19:0]  macPipe [LAT];

   int cyc = 0;
   logic [AW-1:0] addrQ [$];
   logic [127:0]  issPixQ [$];
   logic [127:0]  issWtQ [$];
   int wideCnt = 0;
   int riseCnt = 0;
   int riseCyc = 0;
   int lastIssueCyc = 0;
   logic prevIssue = 1'b0;
   logic prevResValid = 1'b0;

   mac_feeder #(.NUM_CHUNKS(NC), .ADDR_W(AW), .MAC_LATENCY(LAT), .ACC_W(AccW)) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_rdata(weight_rdata),
      .mac_pixels(mac_pixels), .mac_weights(mac_weights), .mac_issue(mac_issue),
      .mac_sum(mac_sum),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [19:0] dot16(input logic [127:0] p, input logic [127:0] w);
      int unsigned s = 0;
      for (int k = 0; k < 16; k++) s += int'(p[8*k +: 8]) * int'(w[8*k +: 8]);
      return 20'(s);
   endfunction

   // Synchronous weight memory and a free-running MAC with LAT cycles of latency.
   always @(posedge clk) begin
      if (weight_rd_en) weight_rdata <= wRow[weight_addr];
      macPipe[0] <= dot16(mac_pixels, mac_weights);
      for (int i = 1; i < LAT; i++) macPipe[i] <= macPipe[i-1];
   end
   assign mac_sum = macPipe[LAT-1];

   always @(negedge clk) begin
      if (rst_n) begin
         if (weight_rd_en) addrQ.push_back(weight_addr);
         if (mac_issue) begin
            issPixQ.push_back(mac_pixels);
            issWtQ.push_back(mac_weights);
            lastIssueCyc <= cyc;
         end
         if (mac_issue && prevIssue) wideCnt <= wideCnt + 1;
         if (res_valid && !prevResValid) begin
            riseCnt <= riseCnt + 1;
            riseCyc <= cyc;
         end
      end
      prevIssue    <= mac_issue;
      prevResValid <= res_valid;
   end

   function automatic logic [127:0] chunkVec(input int c, input bit isWeight);
      logic [127:0] v = '0;
      for (int k = 0; k < 16; k++) v = {v[119:0], isWeight ? wB[c][k] : pixB[c*16+k]};
      return v;
   endfunction

   function automatic logic [AccW-1:0] frameSum();
      longint s = 0;
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < 16; k++) s += longint'(pixB[c*16+k]) * longint'(wB[c][k]);
      return AccW'(s);
   endfunction

   task automatic genFrame(input int mode);
      for (int c = 0; c < NC; c++) begin
         for (int k = 0; k < 16; k++) begin
            case (mode)
               0: begin pixB[c*16+k] = 8'($urandom_range(255)); wB[c][k] = 8'($urandom_range(255)); end
               1: begin pixB[c*16+k] = 8'hFF; wB[c][k] = 8'hFF; end
               2: begin pixB[c*16+k] = 8'(k + 1); wB[c][k] = 8'h02; end
               default: begin
                  pixB[c*16+k] = (c % 2 == 1) ? 8'h02 : 8'h01;
                  wB[c][k]     = (c % 2 == 1) ? 8'h05 : 8'h03;
               end
            endcase
         end
         wRow[c] = chunkVec(c, 1'b1);
      end
   endtask

   task automatic sendBytes(input int first, input int count, input int gapPct);
      int idx = first;
      int guard = 0;
      bit acc;
      while (idx < first + count && guard < 20000) begin
         pix_valid = ($urandom_range(99) >= gapPct);
         pix_data  = pixB[idx];
         acc = pix_valid && pix_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         guard++;
      end
      pix_valid = 1'b0;
      if (idx < first + count) begin
         compared++; mismatched++;
         $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx - first, count);
      end
   endtask

   task automatic runFrame(input int gapPct, input int stall, output logic [AccW-1:0] got);
      int issBase = issPixQ.size();
      int addrBase = addrQ.size();
      int wideBase = wideCnt;
      int riseBase = riseCnt;
      logic [AccW-1:0] exp = frameSum();
      int guard = 0;
      int bad = 0;
      got = '0;
      sendBytes(0, NC*16, gapPct);
      while (!res_valid && guard < 200) begin
         if (pix_ready) bad++;
         @(posedge clk); #1;
         guard++;
      end
      compared++;
      if (res_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL res_timeout: res_valid=%b after %0d cycles, required 1", res_valid, guard);
         return;
      end
      got = res_data;
      compared++;
      if (res_data !== exp) begin
         mismatched++; $display("FAIL res_data: got %0d, required %0d", res_data, exp);
      end
      pix_valid = 1'b1; pix_data = 8'h5A;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_data !== got || pix_ready !== 1'b0) bad++;
      end
      pix_valid = 1'b0; res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      compared++;
      if (bad != 0) begin
         mismatched++; $display("FAIL hold_ready: %0d bad cycles (pix_ready high or result moved), required 0", bad);
      end
      compared++;
      if (res_valid !== 1'b0 || pix_ready !== 1'b1) begin
         mismatched++; $display("FAIL handshake: res_valid=%b pix_ready=%b, required 0 1", res_valid, pix_ready);
      end
      compared++;
      if (riseCyc - lastIssueCyc != LAT + 1) begin
         mismatched++; $display("FAIL latency: %0d cycles issue->result, required %0d", riseCyc - lastIssueCyc, LAT + 1);
      end
      compared++;
      if (addrQ.size() - addrBase != NC) begin
         mismatched++; $display("FAIL rd_count: %0d reads, required %0d", addrQ.size() - addrBase, NC);
      end
      bad = 0;
      for (int i = 0; i < NC && addrBase + i < addrQ.size(); i++)
         if (addrQ[addrBase+i] !== AW'(i)) bad++;
      compared++;
      if (bad != 0) begin
         mismatched++; $display("FAIL addr_seq: %0d addresses out of order, required 0", bad);
      end
      compared++;
      if (issPixQ.size() - issBase != NC) begin
         mismatched++; $display("FAIL issue_count: %0d issues, required %0d", issPixQ.size() - issBase, NC);
      end
      bad = 0;
      for (int c = 0; c < NC && issBase + c < issPixQ.size(); c++) begin
         if (issPixQ[issBase+c] !== chunkVec(c, 1'b0)) bad++;
         if (issWtQ[issBase+c] !== chunkVec(c, 1'b1)) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++; $display("FAIL mac_vectors: %0d wrong pixel/weight vectors, required 0", bad);
      end
      compared++;
      if (wideCnt - wideBase != 0 || riseCnt - riseBase != 1) begin
         mismatched++;
         $display("FAIL pulses: wide issues %0d, result rises %0d, required 0 and 1", wideCnt - wideBase, riseCnt - riseBase);
      end
   endtask

   task automatic checkOutputsZero(input string tag);
      compared++;
      if ({pix_ready, weight_rd_en, mac_issue, res_valid} !== 4'b0 || weight_addr !== '0 ||
          mac_pixels !== '0 || mac_weights !== '0 || res_data !== '0) begin
         mismatched++;
         $display("FAIL %s: rdy=%b rd=%b iss=%b rv=%b addr=%0d pix=%h wt=%h res=%0d, required all 0",
                  tag, pix_ready, weight_rd_en, mac_issue, res_valid, weight_addr, mac_pixels, mac_weights, res_data);
      end
   endtask

   task automatic test_reset();
      #1;
      checkOutputsZero("reset_state");
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      compared++;
      if (pix_ready !== 1'b1) begin
         mismatched++; $display("FAIL ready_after_reset: pix_ready=%b, required 1", pix_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_counting();
      logic [AccW-1:0] got;
      logic [127:0] firstVec = 128'h0102030405060708090A0B0C0D0E0F10;
      int base = issPixQ.size();
      genFrame(2);
      runFrame(0, 0, got);
      compared++;
      if (got !== 26'd13328) begin
         mismatched++; $display("FAIL counting_sum: got %0d, required 13328", got);
      end
      compared++;
      if (issPixQ.size() <= base || issPixQ[base] !== firstVec) begin
         mismatched++; $display("FAIL pack_order: got %h, required %h", issPixQ.size() > base ? issPixQ[base] : '0, firstVec);
      end
   endtask

   task automatic test_all_ones();
      logic [AccW-1:0] got;
      genFrame(1);
      runFrame(0, 0, got);
      compared++;
      if (got !== 26'd50979600) begin
         mismatched++; $display("FAIL all_ones_sum: got %0d, required 50979600", got);
      end
   endtask

   task automatic test_gaps();
      logic [AccW-1:0] got;
      genFrame(2);
      runFrame(50, 0, got);
      compared++;
      if (got !== 26'd13328) begin
         mismatched++; $display("FAIL gaps_sum: got %0d, required 13328", got);
      end
   endtask

   task automatic test_result_stall();
      logic [AccW-1:0] got;
      genFrame(0);
      runFrame(20, 10, got);
      genFrame(0);
      runFrame(0, 0, got);
   endtask

   task automatic test_two_pattern();
      logic [AccW-1:0] got;
      genFrame(3);
      runFrame(0, 3, got);
      compared++;
      if (got !== 26'd5040) begin
         mismatched++; $display("FAIL two_pattern_sum: got %0d, required 5040", got);
      end
   endtask

   task automatic test_back_to_back();
      logic [AccW-1:0] got;
      for (int f = 0; f < 2; f++) begin
         genFrame(0);
         runFrame(30, 0, got);
      end
   endtask

   task automatic test_reset_midframe();
      logic [AccW-1:0] got;
      genFrame(0);
      sendBytes(0, 2*16 + 7, 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutputsZero("midframe_reset");
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      genFrame(0);
      runFrame(0, 0, got);
   endtask

   initial begin
      test_reset();
      test_counting();
      test_all_ones();
      test_gaps();
      test_result_stall();
      test_two_pattern();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
